debug_trace_buffer: RTL and testbench

Trace-capture receiver for the CPU debug port: sits beside `cpu` and consumes its `debug_*` outputs, recording one record per retired instruction into a circular buffer. Recording is armed by the user, stops after a programmable number of records following a PC-match trigger, and the captured records are then drained oldest-first through a simple read handshake. Used in simulation benches and on-board debug in place of manual waveform inspection.

---
 rtl/debug_trace_buffer.sv | 128 ++++++++++++
 tb/tb_debug_trace_buffer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/debug_trace_buffer.sv
// Trace-capture receiver for the CPU debug port: records one entry per retired
// instruction into a circular buffer, stops after a PC-match trigger plus a post count.
module debug_trace_buffer #(
   parameter int STAGE_COUNT   = 5,
   parameter int CAPTURE_STAGE = 4,
   parameter int I_ADDR_WIDTH  = 10,
   parameter int D_ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH    = 8,
   parameter int PTR_WIDTH     = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [STAGE_COUNT-1:0]  debug_pipeline_stage,
   input  logic [I_ADDR_WIDTH-1:0] debug_program_counter,
   input  logic [D_ADDR_WIDTH-1:0] debug_bus_address,
   input  logic [DATA_WIDTH-1:0]   debug_writeback_value,
   input  logic [11:0]             debug_opcode_imd,
   input  logic                    arm,
   input  logic                    stop,
   input  logic                    trigger_en,
   input  logic [I_ADDR_WIDTH-1:0] trigger_pc,
   input  logic [PTR_WIDTH-1:0]    post_count,
   input  logic                    rd_en,
   output logic                    rd_valid,
   output logic [I_ADDR_WIDTH-1:0] rd_pc,
   output logic [D_ADDR_WIDTH-1:0] rd_bus_address,
   output logic [DATA_WIDTH-1:0]   rd_writeback,
   output logic [11:0]             rd_opcode_imd,
   output logic [1:0]              trace_state,
   output logic [PTR_WIDTH:0]      trace_count,
   output logic                    wrapped
);

   localparam int DEPTH = 2 ** PTR_WIDTH;
   localparam int REC_W = I_ADDR_WIDTH + D_ADDR_WIDTH + DATA_WIDTH + 12;
   localparam logic [PTR_WIDTH:0] FULL = (PTR_WIDTH + 1)'(DEPTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PRE  = 2'd1;
   localparam logic [1:0] POST = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [REC_W-1:0]     mem [DEPTH];
   logic [REC_W-1:0]     rec;
   logic [REC_W-1:0]     rd_rec;
   logic [PTR_WIDTH-1:0] wr_ptr;
   logic [PTR_WIDTH-1:0] rd_ptr;
   logic [PTR_WIDTH-1:0] post_left;
   logic                 cap;
   logic                 trig_hit;
   logic                 rd_fire;
   logic                 unused_stage_bits;

   assign unused_stage_bits = ^debug_pipeline_stage;

   assign rec = {debug_program_counter, debug_bus_address, debug_writeback_value, debug_opcode_imd};

   // Oldest record sits trace_count entries behind the write pointer; a full
   // buffer truncates to wr_ptr itself, which is exactly the oldest slot.
   assign rd_ptr = wr_ptr - trace_count[PTR_WIDTH-1:0];
   assign rd_rec = mem[rd_ptr];

   assign cap      = debug_pipeline_stage[CAPTURE_STAGE] && !arm &&
                     ((trace_state == PRE) || (trace_state == POST));
   assign trig_hit = cap && trigger_en && (debug_program_counter == trigger_pc);
   assign rd_fire  = rd_en && !arm && (trace_state == DONE) && (trace_count != '0);

   always_ff @(posedge clk) begin
      if (cap) mem[wr_ptr] <= rec;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trace_state    <= IDLE;
         wr_ptr         <= '0;
         trace_count    <= '0;
         wrapped        <= 1'b0;
         post_left      <= '0;
         rd_valid       <= 1'b0;
         rd_pc          <= '0;
         rd_bus_address <= '0;
         rd_writeback   <= '0;
         rd_opcode_imd  <= '0;
      end else begin
         rd_valid <= 1'b0;
         if (arm) begin
            trace_state <= PRE;
            wr_ptr      <= '0;
            trace_count <= '0;
            wrapped     <= 1'b0;
            post_left   <= '0;
         end else begin
            if (cap) begin
               wr_ptr <= wr_ptr + 1'b1;
               if (trace_count == FULL) wrapped <= 1'b1;
               else                     trace_count <= trace_count + 1'b1;
            end
            case (trace_state)
               PRE: begin
                  if (stop) begin
                     trace_state <= DONE;
                  end else if (trig_hit) begin
                     post_left   <= post_count;
                     trace_state <= (post_count == '0) ? DONE : POST;
                  end
               end
               POST: begin
                  if (stop) begin
                     trace_state <= DONE;
                  end else if (cap) begin
                     post_left <= post_left - 1'b1;
                     if (post_left == PTR_WIDTH'(1)) trace_state <= DONE;
                  end
               end
               DONE: begin
                  if (rd_fire) begin
                     rd_valid       <= 1'b1;
                     {rd_pc, rd_bus_address, rd_writeback, rd_opcode_imd} <= rd_rec;
                     trace_count    <= trace_count - 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Randomized and directed bench for debug_trace_buffer, checked against a
// queue-based model of the capture/trigger/readout rules.
module tb_debug_trace_buffer;

   localparam int REC_W = 38;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  debug_pipeline_stage;
   logic [9:0]  debug_program_counter;
   logic [7:0]  debug_bus_address;
   logic [7:0]  debug_writeback_value;
   logic [11:0] debug_opcode_imd;
   logic        arm, stop, trigger_en, rd_en;
   logic [9:0]  trigger_pc;
   logic [3:0]  post_count;
   logic        rd_valid;
   logic [9:0]  rd_pc;
   logic [7:0]  rd_bus_address;
   logic [7:0]  rd_writeback;
   logic [11:0] rd_opcode_imd;
   logic [1:0]  trace_state;
   logic [4:0]  trace_count;
   logic        wrapped;

   int total = 0;
   int bad   = 0;

   int              m_state;
   logic [REC_W-1:0] m_q[$];
   bit              m_wrapped;
   int              m_left;
   logic [REC_W-1:0] m_last;
   bit              m_rdv;

   always #5 clk = ~clk;

   debug_trace_buffer dut (
      .clk(clk), .reset(reset),
      .debug_pipeline_stage(debug_pipeline_stage),
      .debug_program_counter(debug_program_counter),
      .debug_bus_address(debug_bus_address),
      .debug_writeback_value(debug_writeback_value),
      .debug_opcode_imd(debug_opcode_imd),
      .arm(arm), .stop(stop), .trigger_en(trigger_en), .trigger_pc(trigger_pc),
      .post_count(post_count), .rd_en(rd_en),
      .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_bus_address(rd_bus_address),
      .rd_writeback(rd_writeback), .rd_opcode_imd(rd_opcode_imd),
      .trace_state(trace_state), .trace_count(trace_count), .wrapped(wrapped)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state   = 0;
      m_q.delete();
      m_wrapped = 0;
      m_left    = 0;
      m_last    = '0;
      m_rdv     = 0;
   endtask

   task automatic check_all();
      chk("state", 64'(trace_state), 64'(m_state));
      chk("count", 64'(trace_count), 64'(m_q.size()));
      chk("wrapped", 64'(wrapped), 64'(m_wrapped));
      chk("rd_valid", 64'(rd_valid), 64'(m_rdv));
      chk("rd_rec", 64'({rd_pc, rd_bus_address, rd_writeback, rd_opcode_imd}), 64'(m_last));
   endtask

   // One clock: drive inputs, advance the model, then compare after the edge.
   task automatic cycle(input logic [4:0] stg, input logic [9:0] pc,
                        input logic arm_i, input logic stop_i, input logic rd_i);
      logic [REC_W-1:0] r;
      bit cap;
      int nstate;
      debug_pipeline_stage  = stg;
      debug_program_counter = pc;
      debug_bus_address     = 8'($urandom);
      debug_writeback_value = 8'($urandom);
      debug_opcode_imd      = 12'($urandom);
      arm = arm_i; stop = stop_i; rd_en = rd_i;
      r = {pc, debug_bus_address, debug_writeback_value, debug_opcode_imd};
      m_rdv = 0;
      if (arm_i) begin
         m_q.delete(); m_wrapped = 0; m_left = 0; m_state = 1;
      end else begin
         cap = stg[4] && (m_state == 1 || m_state == 2);
         nstate = m_state;
         if ((m_state == 1 || m_state == 2) && stop_i) nstate = 3;
         else if (m_state == 1 && cap && trigger_en && pc == trigger_pc) begin
            m_left = int'(post_count);
            nstate = (post_count == 0) ? 3 : 2;
         end else if (m_state == 2 && cap) begin
            m_left--;
            if (m_left == 0) nstate = 3;
         end
         if (cap) begin
            m_q.push_back(r);
            if (m_q.size() > 16) begin
               void'(m_q.pop_front());
               m_wrapped = 1;
            end
         end
         if (m_state == 3 && rd_i && m_q.size() > 0) begin
            m_rdv  = 1;
            m_last = m_q.pop_front();
         end
         m_state = nstate;
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic wb(input logic [9:0] pc);
      cycle(5'b10000, pc, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic rd();
      cycle(5'b00001, 10'($urandom), 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      reset = 1'b1;
      debug_pipeline_stage = '0; debug_program_counter = '0; debug_bus_address = '0;
      debug_writeback_value = '0; debug_opcode_imd = '0;
      arm = 0; stop = 0; rd_en = 0; trigger_en = 0; trigger_pc = '0; post_count = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      reset = 1'b0;

      // Idle with writeback pulses: nothing recorded, reads ignored
      for (int i = 0; i < 10; i++)
         cycle((i % 2) ? 5'b10000 : 5'b00010, 10'(i), 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      chk("idle_state", 64'(trace_state), 64'd0);

      // Trigger at 0x005 with two post records
      trigger_en = 1; trigger_pc = 10'h005; post_count = 4'd2;
      cycle(5'b00001, 10'h0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         wb(10'(i));
         cycle(5'b00100, 10'h3ff, 1'b0, 1'b0, 1'b0);
      end
      chk("t2_state", 64'(trace_state), 64'd3);
      chk("t2_count", 64'(trace_count), 64'd8);
      for (int i = 0; i < 8; i++) begin
         rd();
         chk("t2_pc", 64'(rd_pc), 64'(i));
      end

      // Free-running wrap, then stop
      trigger_en = 0;
      cycle(5'b00001, 10'h0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) wb(10'(i));
      cycle(5'b00001, 10'h0, 1'b0, 1'b1, 1'b0);
      chk("t3_count", 64'(trace_count), 64'd16);
      chk("t3_wrapped", 64'(wrapped), 64'd1);
      for (int i = 0; i < 16; i++) begin
         rd();
         chk("t3_pc", 64'(rd_pc), 64'(4 + i));
      end

      // Trigger on the first record, no post records
      trigger_en = 1; trigger_pc = 10'h02a; post_count = 4'd0;
      cycle(5'b00001, 10'h0, 1'b1, 1'b0, 1'b0);
      wb(10'h02a);
      chk("t4_state", 64'(trace_state), 64'd3);
      chk("t4_count", 64'(trace_count), 64'd1);
      rd();
      chk("t4_pc", 64'(rd_pc), 64'h02a);
      rd();
      chk("t4_empty_rd", 64'(rd_valid), 64'd0);

      // Re-arm colliding with a POST capture
      trigger_pc = 10'h003; post_count = 4'd5;
      cycle(5'b00001, 10'h0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) wb(10'(i));
      chk("t5_post", 64'(trace_state), 64'd2);
      cycle(5'b10000, 10'h077, 1'b1, 1'b0, 1'b0);
      chk("t5_state", 64'(trace_state), 64'd1);
      chk("t5_count", 64'(trace_count), 64'd0);
      wb(10'h008);
      cycle(5'b00001, 10'h0, 1'b0, 1'b1, 1'b0);
      rd();
      chk("t5_pc", 64'(rd_pc), 64'h008);
      rd();

      // Reset in the middle of readout
      trigger_en = 0;
      cycle(5'b00001, 10'h0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) wb(10'(16 + i));
      cycle(5'b00001, 10'h0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) rd();
      rd_en = 1;
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_all();
      chk("t6_state", 64'(trace_state), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      rd_en = 0;
      check_all();

      // Randomized sessions
      for (int s = 0; s < 10; s++) begin
         trigger_en = 1'($urandom_range(0, 1));
         trigger_pc = 10'($urandom_range(0, 15));
         post_count = 4'($urandom);
         cycle(5'b00001, 10'h0, 1'b1, 1'b0, 1'b0);
         for (int c = 0; c < 60; c++)
            cycle(($urandom_range(0, 1) == 1) ? 5'b10000 : 5'(1 << $urandom_range(0, 3)),
                  10'($urandom_range(0, 15)),
                  1'($urandom_range(0, 99) == 0),
                  1'($urandom_range(0, 59) == 0),
                  1'($urandom_range(0, 1)));
         cycle(5'b00001, 10'h0, 1'b0, 1'b1, 1'b0);
         for (int c = 0; c < 20; c++)
            cycle(5'(1 << $urandom_range(0, 4)), 10'($urandom), 1'b0, 1'b0,
                  1'($urandom_range(0, 3) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
